iir_filter_mc: RTL and testbench

Parametrised, multi-channel, first-order recursive filter computing y[n] = sat(x[n] + (a·y[n-1]) >>> CF) per channel, with signed fixed-point arithmetic. It time-multiplexes one iterative radix-2 Booth multiplier across CH independent channels. Each channel has its own coefficient register and its own feedback state. It sits between the sample source and the downstream DSP chain. It adds what the single-channel 4-bit version lacks: signed Qm.CF coefficients, saturation, valid/ready handshakes and run-time coefficient loading.

---
 rtl/iir_filter_mc.sv | 150 +++++++++++++++
 tb/tb_iir_filter_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_filter_mc.sv
// Multi-channel first-order IIR: y = sat(x + (a*y_prev) >>> CF), one shared
// iterative radix-2 Booth multiplier time-multiplexed across CH channels.
module iir_filter_mc #(
    parameter int W   = 8,
    parameter int CW  = 8,
    parameter int CF  = 6,
    parameter int CH  = 4,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHW-1:0]        in_ch,
    input  logic signed [W-1:0]   in_x,
    input  logic                  coef_we,
    input  logic [CHW-1:0]        coef_ch,
    input  logic signed [CW-1:0]  coef_a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHW-1:0]        out_ch,
    output logic signed [W-1:0]   out_y,
    output logic                  out_sat
);
    localparam int PW   = W + CW;
    localparam int SW   = PW + 1;
    localparam int CNTW = $clog2(CW + 1);
    localparam logic [CNTW-1:0]     CNT_LAST = CNTW'(CW - 1);
    localparam logic [CHW:0]        CH_LIM   = (CHW + 1)'(CH);
    localparam logic signed [SW-1:0] SMAX    = SW'((64'sd1 <<< (W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN    = ~SMAX;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    state_t st, st_nx;
    logic [CH-1:0][W-1:0]  st_mem;
    logic [CH-1:0][CW-1:0] cf_mem;

    logic [CHW-1:0]        ch_q;
    logic signed [W-1:0]   x_q, m_q;
    logic signed [W:0]     acc, acc_add, m_ext;
    logic [CW-1:0]         q;
    logic                  q_1;
    logic [CNTW-1:0]       cnt;
    logic                  bad_q;
    logic                  in_ok, coef_ok;
    logic signed [PW-1:0]  prod, prod_sh;
    logic signed [SW-1:0]  p_ext, x_ext, sum;
    logic                  clip_hi, clip_lo;
    logic signed [W-1:0]   y_sat;

    assign in_ok   = {1'b0, in_ch} < CH_LIM;
    assign coef_ok = {1'b0, coef_ch} < CH_LIM;

    // Booth step: inspect {q[0], q_1}, add/sub multiplicand into the upper half.
    assign m_ext = {m_q[W-1], m_q};
    always_comb begin
        acc_add = acc;
        case ({q[0], q_1})
            2'b01:   acc_add = acc + m_ext;
            2'b10:   acc_add = acc - m_ext;
            default: acc_add = acc;
        endcase
    end

    // One guard bit in acc keeps -2^(W-1) subtractions exact; the product needs only PW bits.
    assign prod    = {acc[W-1:0], q};
    assign prod_sh = prod >>> CF;
    assign p_ext   = {prod_sh[PW-1], prod_sh};
    assign x_ext   = {{(SW-W){x_q[W-1]}}, x_q};
    assign sum     = p_ext + x_ext;
    assign clip_hi = sum > SMAX;
    assign clip_lo = sum < SMIN;
    assign y_sat   = clip_hi ? SMAX[W-1:0] : (clip_lo ? SMIN[W-1:0] : sum[W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE: if (in_valid)           st_nx = MUL;
            MUL:  if (cnt == CNT_LAST)    st_nx = ACC;
            ACC:                          st_nx = OUT;
            OUT:  if (out_ready)          st_nx = IDLE;
            default:                      st_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (st == IDLE);
        out_valid = (st == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q    <= '0;
            x_q     <= '0;
            m_q     <= '0;
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            bad_q   <= 1'b0;
            out_ch  <= '0;
            out_y   <= '0;
            out_sat <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    ch_q  <= in_ch;
                    x_q   <= in_x;
                    m_q   <= in_ok ? st_mem[in_ch] : '0;
                    q     <= in_ok ? cf_mem[in_ch] : '0;
                    acc   <= '0;
                    q_1   <= 1'b0;
                    cnt   <= '0;
                    bad_q <= !in_ok;
                end
                MUL: begin
                    acc <= {acc_add[W], acc_add[W:1]};
                    q   <= {acc_add[0], q[CW-1:1]};
                    q_1 <= q[0];
                    cnt <= cnt + CNTW'(1);
                end
                ACC: begin
                    out_ch  <= ch_q;
                    out_y   <= bad_q ? '0 : y_sat;
                    out_sat <= !bad_q && (clip_hi || clip_lo);
                end
                default: ;
            endcase
        end
    end

    // Accept reads cf_mem before a same-edge write lands, so it sees the old coefficient.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mem <= '0;
            cf_mem <= '0;
        end else begin
            if (coef_we && coef_ok)
                cf_mem[coef_ch] <= coef_a;
            if (st == ACC && !bad_q)
                st_mem[ch_q] <= y_sat;
        end
    end
endmodule

// File: tb/tb_iir_filter_mc.sv
// Randomized and directed bench for iir_filter_mc against a per-channel arithmetic model.
module tb_iir_filter_mc;
    localparam int W = 8, CW = 8, CF = 6, CH = 4, CHW = 2;
    localparam int YMAX = (1 << (W - 1)) - 1;
    localparam int YMIN = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic signed [W-1:0] in_x = '0;
    logic coef_we = 1'b0;
    logic [CHW-1:0] coef_ch = '0;
    logic signed [CW-1:0] coef_a = '0;
    logic out_valid, out_ready = 1'b0;
    logic [CHW-1:0] out_ch;
    logic signed [W-1:0] out_y;
    logic out_sat;

    int total = 0, passed = 0;
    int m_st[CH];
    int m_cf[CH];

    iir_filter_mc #(.W(W), .CW(CW), .CF(CF), .CH(CH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_x(in_x), .coef_we(coef_we), .coef_ch(coef_ch),
        .coef_a(coef_a), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_y(out_y), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // y = clamp(x + floor(a*s / 2^CF)), state takes the clamped value
    function automatic void model_step(input int ch, input int x, output int y, output bit s);
        int p, d, r, v;
        d = 1 << CF;
        p = m_cf[ch] * m_st[ch];
        r = p % d;
        if (r < 0) r += d;
        v = x + (p - r) / d;
        s = 1'b0;
        if (v > YMAX) begin v = YMAX; s = 1'b1; end
        else if (v < YMIN) begin v = YMIN; s = 1'b1; end
        y = v;
        m_st[ch] = v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin m_st[i] = 0; m_cf[i] = 0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic set_coef(input int ch, input int a);
        coef_we = 1'b1; coef_ch = CHW'(ch); coef_a = CW'(a);
        @(posedge clk); #1;
        coef_we = 1'b0;
        m_cf[ch] = a;
    endtask

    task automatic send(input int ch, input int x, input bit wr, input int wa);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; in_ch = CHW'(ch); in_x = W'(x);
        coef_we = wr; coef_ch = CHW'(ch); coef_a = CW'(wa);
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0;
    endtask

    task automatic recv(input int hold, output int y, output bit s, output int och, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        y = int'(out_y); s = out_sat; och = int'(out_ch);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic sample(input int ch, input int x, input bit wr, input int wa, input int hold,
                          output int y, output bit s, output int och, output int lat,
                          output int ey, output bit es);
        send(ch, x, wr, wa);
        model_step(ch, x, ey, es);
        if (wr) m_cf[ch] = wa;
        recv(hold, y, s, och, lat);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== '0 || out_ch !== '0 || out_sat !== 1'b0)
            $display("FAIL reset got valid=%0b ready=%0b y=%0d ch=%0d sat=%0b exp 0 1 0 0 0",
                     out_valid, in_ready, out_y, out_ch, out_sat);
        else passed++;
    endtask

    task automatic test_impulse();
        int exp_y[4] = '{64, 32, 16, 8};
        int y, och, lat, ey; bit s, es;
        set_coef(0, 32);
        for (int i = 0; i < 4; i++) begin
            sample(0, (i == 0) ? 64 : 0, 1'b0, 0, 0, y, s, och, lat, ey, es);
            total++;
            if (y !== exp_y[i] || y !== ey || s !== 1'b0 || och !== 0 || lat !== CW + 1)
                $display("FAIL impulse[%0d] got y=%0d sat=%0b ch=%0d lat=%0d exp y=%0d sat=0 ch=0 lat=%0d",
                         i, y, s, och, lat, exp_y[i], CW + 1);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        int px[3] = '{100, 100, 0};
        int py[3] = '{100, 127, 127};
        bit ps[3] = '{1'b0, 1'b1, 1'b0};
        int nx[2] = '{-100, -100};
        int ny[2] = '{-100, -128};
        bit ns[2] = '{1'b0, 1'b1};
        int y, och, lat, ey; bit s, es;
        set_coef(1, 64);
        for (int i = 0; i < 3; i++) begin
            sample(1, px[i], 1'b0, 0, 0, y, s, och, lat, ey, es);
            total++;
            if (y !== py[i] || s !== ps[i] || y !== ey || s !== es || och !== 1)
                $display("FAIL sat_pos[%0d] got y=%0d sat=%0b ch=%0d exp y=%0d sat=%0b ch=1",
                         i, y, s, och, py[i], ps[i]);
            else passed++;
        end
        do_reset();
        set_coef(1, 64);
        for (int i = 0; i < 2; i++) begin
            sample(1, nx[i], 1'b0, 0, 0, y, s, och, lat, ey, es);
            total++;
            if (y !== ny[i] || s !== ns[i] || y !== ey || s !== es)
                $display("FAIL sat_neg[%0d] got y=%0d sat=%0b exp y=%0d sat=%0b", i, y, s, ny[i], ns[i]);
            else passed++;
        end
    endtask

    task automatic test_sign();
        int y, och, lat, ey; bit s, es;
        set_coef(2, -32);
        sample(2, 64, 1'b0, 0, 0, y, s, och, lat, ey, es);
        total++;
        if (y !== 64 || y !== ey) $display("FAIL neg_coef0 got y=%0d exp y=64", y);
        else passed++;
        sample(2, 0, 1'b0, 0, 0, y, s, och, lat, ey, es);
        total++;
        if (y !== -32 || y !== ey || s !== 1'b0) $display("FAIL neg_coef1 got y=%0d sat=%0b exp y=-32 sat=0", y, s);
        else passed++;
        set_coef(3, 0);
        sample(3, -1, 1'b0, 0, 0, y, s, och, lat, ey, es);
        set_coef(3, 32);
        sample(3, 0, 1'b0, 0, 0, y, s, och, lat, ey, es);
        total++;
        if (y !== -1 || y !== ey) $display("FAIL floor got y=%0d exp y=-1", y);
        else passed++;
    endtask

    task automatic test_interleave();
        int seq_ch[6] = '{0, 1, 0, 1, 0, 1};
        int seq_x[6]  = '{64, 64, 0, 0, 0, 0};
        int seq_y[6]  = '{64, 64, 32, 48, 16, 36};
        int y, och, lat, ey; bit s, es;
        do_reset();
        set_coef(0, 32);
        set_coef(1, 48);
        for (int i = 0; i < 6; i++) begin
            sample(seq_ch[i], seq_x[i], 1'b0, 0, 0, y, s, och, lat, ey, es);
            total++;
            if (y !== seq_y[i] || y !== ey || och !== seq_ch[i])
                $display("FAIL interleave[%0d] got y=%0d ch=%0d exp y=%0d ch=%0d", i, y, och, seq_y[i], seq_ch[i]);
            else passed++;
        end
        send(0, 0, 1'b0, 0);
        model_step(0, 0, ey, es);
        set_coef(0, 64);
        recv(0, y, s, och, lat);
        total++;
        if (y !== 8 || y !== ey) $display("FAIL coef_midop got y=%0d exp y=8", y);
        else passed++;
        sample(0, 0, 1'b0, 0, 0, y, s, och, lat, ey, es);
        total++;
        if (y !== 8 || y !== ey) $display("FAIL coef_next got y=%0d exp y=8", y);
        else passed++;
        sample(1, 0, 1'b0, 0, 0, y, s, och, lat, ey, es);
        total++;
        if (y !== 27 || y !== ey) $display("FAIL isolation got y=%0d exp y=27", y);
        else passed++;
    endtask

    task automatic test_backpressure();
        int ey, n; bit es;
        logic signed [W-1:0] y0;
        set_coef(2, 40);
        send(2, 10, 1'b0, 0);
        model_step(2, 10, ey, es);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        y0 = out_y;
        total++;
        if (out_valid !== 1'b1 || int'(y0) !== ey || out_ch !== 2'd2)
            $display("FAIL bp_first got valid=%0b y=%0d ch=%0d exp valid=1 y=%0d ch=2", out_valid, y0, out_ch, ey);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== y0 || out_ch !== 2'd2)
                $display("FAIL bp_hold[%0d] got valid=%0b ready=%0b y=%0d exp valid=1 ready=0 y=%0d",
                         i, out_valid, in_ready, out_y, y0);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release got ready=%0b valid=%0b exp ready=1 valid=0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int y, och, lat, ey; bit s, es;
        send(0, 64, 1'b0, 0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== '0 || out_ch !== '0 || out_sat !== 1'b0)
            $display("FAIL reset_mid got valid=%0b ready=%0b y=%0d ch=%0d sat=%0b exp 0 1 0 0 0",
                     out_valid, in_ready, out_y, out_ch, out_sat);
        else passed++;
        rst = 1'b0;
        model_clear();
        set_coef(0, 64);
        sample(0, 64, 1'b0, 0, 0, y, s, och, lat, ey, es);
        total++;
        if (y !== 64 || y !== ey || s !== 1'b0) $display("FAIL reset_state got y=%0d sat=%0b exp y=64 sat=0", y, s);
        else passed++;
    endtask

    task automatic test_random();
        int y, och, lat, ey, ch, x, wa, hold; bit s, es, wr;
        do_reset();
        for (int i = 0; i < CH; i++) set_coef(i, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                set_coef(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)) - 128);
            ch   = int'($urandom_range(0, CH - 1));
            x    = int'($urandom_range(0, 255)) - 128;
            wr   = ($urandom_range(0, 3) == 0);
            wa   = int'($urandom_range(0, 255)) - 128;
            hold = int'($urandom_range(0, 3));
            sample(ch, x, wr, wa, hold, y, s, och, lat, ey, es);
            total++;
            if (y !== ey || s !== es || och !== ch || lat !== CW + 1)
                $display("FAIL random[%0d] got y=%0d sat=%0b ch=%0d lat=%0d exp y=%0d sat=%0b ch=%0d lat=%0d",
                         i, y, s, och, lat, ey, es, ch, CW + 1);
            else passed++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_saturation();
        test_sign();
        test_interleave();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
